// File: rtl/display_scan.sv
// display_scan: time-multiplexed 4-digit 7-segment scanner with frame-synchronous word update
module display_scan #(
    parameter int CLK_DIV = 50000,
    parameter int DEAD    = 16,
    parameter bit LZB     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  blank_mask,
    output logic [3:0]  nibble,
    output logic [3:0]  an,
    output logic [1:0]  digit_sel,
    output logic        frame_tick
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DEAD_C = CW'(DEAD);
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   pend;
    logic [15:0]   disp;
    logic          pend_v;
    logic [3:0]    mask_q;
    logic [3:0]    lz;
    logic [3:0]    dark;
    logic          last;
    logic          bnd;
    // slot/frame decode, leading-zero detection and output drive from registered state only
    always_comb begin
        last       = cnt == LAST;
        bnd        = last && idx == 2'd3;
        lz[3]      = disp[15:12] == 4'd0;
        lz[2]      = lz[3] && disp[11:8] == 4'd0;
        lz[1]      = lz[2] && disp[7:4] == 4'd0;
        lz[0]      = 1'b0;
        dark       = mask_q | (LZB ? lz : 4'b0000);
        nibble     = disp[4*idx +: 4];
        digit_sel  = idx;
        frame_tick = bnd;
        an         = (cnt < DEAD_C || dark[idx]) ? 4'b1111 : ~(4'b0001 << idx);
    end
    // prescaler, digit walk, and anti-tearing word hand-off at the frame boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            idx    <= '0;
            pend   <= '0;
            pend_v <= 1'b0;
            disp   <= '0;
            mask_q <= '0;
        end else begin
            cnt    <= last ? '0 : cnt + 1'b1;
            idx    <= last ? idx + 2'd1 : idx;
            mask_q <= blank_mask;
            if (bnd) begin
                pend_v <= 1'b0;
                if (load)
                    disp <= value;
                else if (pend_v)
                    disp <= pend;
            end else if (load) begin
                pend   <= value;
                pend_v <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: scoreboard bench for display_scan against a time-based reference model
module tb_display_scan;
    localparam int CD = 8;
    localparam int DT = 2;
    localparam int FR = 4 * CD;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  blank_mask = '0;
    logic [3:0]  nibble, an, nibble0, an0;
    logic [1:0]  digit_sel, digit_sel0;
    logic        frame_tick, frame_tick0;

    always #5 clk = ~clk;

    display_scan #(.CLK_DIV(CD), .DEAD(DT), .LZB(1'b1)) dut (
        .clk(clk), .rst(rst), .load(load), .value(value), .blank_mask(blank_mask),
        .nibble(nibble), .an(an), .digit_sel(digit_sel), .frame_tick(frame_tick)
    );

    display_scan #(.CLK_DIV(CD), .DEAD(DT), .LZB(1'b0)) dut0 (
        .clk(clk), .rst(rst), .load(load), .value(value), .blank_mask(blank_mask),
        .nibble(nibble0), .an(an0), .digit_sel(digit_sel0), .frame_tick(frame_tick0)
    );

    typedef struct packed {
        logic [3:0] nib;
        logic [3:0] an;
        logic [3:0] an0;
        logic [1:0] sel;
        logic       ft;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          mt = 0;
    logic [15:0] m_disp = '0;
    logic [15:0] m_pend = '0;
    bit          m_pv = 0;
    bit          seen = 0;
    logic [3:0]  m_mask = '0;
    int          checks = 0;
    int          errors = 0;

    // expected outputs from elapsed time since reset and the word on show
    function automatic exp_t predict();
        exp_t r;
        int slot;
        int pos;
        logic [15:0] up;
        logic off;
        slot  = (mt / CD) % 4;
        pos   = mt % CD;
        up    = m_disp >> (4 * slot);
        off   = pos < DT;
        r.nib = up[3:0];
        r.sel = slot[1:0];
        r.ft  = (mt % FR) == FR - 1;
        r.an  = (off || m_mask[slot] || (slot > 0 && up == 16'd0)) ? 4'hf : ~(4'b0001 << slot);
        r.an0 = (off || m_mask[slot]) ? 4'hf : ~(4'b0001 << slot);
        return r;
    endfunction

    // reference model: advance on each edge, queue the expectation for the new cycle
    always @(posedge clk) begin
        if (rst) begin
            mt     = 0;
            m_disp = '0;
            m_pv   = 0;
            m_mask = '0;
            seen   = 1;
        end else if (seen) begin
            if (mt % FR == FR - 1) begin
                if (load)
                    m_disp = value;
                else if (m_pv)
                    m_disp = m_pend;
                m_pv = 0;
            end else if (load) begin
                m_pend = value;
                m_pv   = 1;
            end
            m_mask = blank_mask;
            mt++;
        end
        if (seen)
            q.push_back(predict());
    end

    task automatic chk(input string n, input logic [3:0] a, input logic [3:0] r);
        checks++;
        if (a !== r) begin
            errors++;
            $display("FAIL %s t=%0d got %h want %h", n, mt, a, r);
        end
    endtask

    // monitor: compare DUT outputs mid-cycle against the queued expectation
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("nibble", nibble, e.nib);
            chk("an", an, e.an);
            chk("an_nolzb", an0, e.an0);
            chk("digit_sel", {2'b00, digit_sel}, {2'b00, e.sel});
            chk("frame_tick", {3'b000, frame_tick}, {3'b000, e.ft});
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_phase(input int p);
        for (int i = 0; i < FR && (mt % FR) != p; i++)
            cyc();
    endtask

    task automatic ld(input logic [15:0] v);
        load  = 1'b1;
        value = v;
        cyc();
        load  = 1'b0;
    endtask

    initial begin
        cyc(3);
        rst = 1'b0;
        cyc(40);
        wait_phase(12);
        ld(16'hA5C3);
        cyc(80);
        wait_phase(3);
        ld(16'h0040);
        cyc(70);
        ld(16'h0000);
        cyc(70);
        blank_mask = 4'b0001;
        ld(16'h1234);
        cyc(70);
        blank_mask = 4'b0000;
        wait_phase(FR - 1);
        ld(16'hBEEF);
        cyc(40);
        wait_phase(5);
        ld(16'h1111);
        cyc(6);
        ld(16'h2222);
        cyc(70);
        wait_phase(8);
        ld(16'h9999);
        cyc(3);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(70);
        repeat (800) begin
            load  = $urandom_range(7) == 0;
            value = 16'($urandom);
            rst   = $urandom_range(199) == 0;
            if ($urandom_range(15) == 0)
                blank_mask = 4'($urandom);
            cyc();
        end
        load = 1'b0;
        rst  = 1'b0;
        cyc(40);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
